eta_poly_pack: RTL and testbench

ETA_POLY_PACK -- requirements
Module: eta_poly_pack

---
 rtl/eta_poly_pack.sv | 137 +++++++++++++
 tb/tb_eta_poly_pack.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/eta_poly_pack.sv
// rtl/eta_poly_pack.sv - packs a polynomial of small signed coefficients into a stream of fixed-width words
// Each coefficient c becomes (ETA - c) mod 2^B, concatenated LSB first and emitted one word per handshake.
module eta_poly_pack #(
   parameter int N             = 256,
   parameter int ETA           = 2,
   parameter int COEFF_WIDTH   = 4,
   parameter int DATA_OUT_BITS = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [COEFF_WIDTH*N-1:0]   poly_in,
   output logic [DATA_OUT_BITS-1:0]   data_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int B     = (ETA == 4) ? 4 : 3;
   localparam int WORDS = N * B / DATA_OUT_BITS;
   localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int EW    = COEFF_WIDTH + 2;
   localparam logic signed [EW-1:0] ETA_S   = EW'(ETA);
   localparam logic        [CW-1:0] CNT_END = CW'(WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [COEFF_WIDTH*N-1:0]   poly_q, poly_d;
   logic [DATA_OUT_BITS-1:0]   data_q, data_d;
   logic                       valid_q, valid_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       err_q, err_d;

   logic                       accept_start;
   logic [COEFF_WIDTH*N-1:0]   src;
   logic [N*B-1:0]             packed_bits;
   logic                       bad;
   logic signed [EW-1:0]       c_ext;
   logic signed [EW-1:0]       p_ext;

   assign accept_start = (state_q == S_IDLE) && start;
   // On the accepting cycle the latch is not yet loaded, so word 0 is packed straight from poly_in.
   assign src = accept_start ? poly_in : poly_q;

   always_comb begin
      packed_bits = '0;
      bad         = 1'b0;
      c_ext       = '0;
      p_ext       = '0;
      for (int i = 0; i < N; i++) begin
         c_ext = {{2{src[i*COEFF_WIDTH+COEFF_WIDTH-1]}}, src[i*COEFF_WIDTH +: COEFF_WIDTH]};
         p_ext = ETA_S - c_ext;
         packed_bits[i*B +: B] = p_ext[B-1:0];
         if ((c_ext > ETA_S) || (c_ext < -ETA_S)) begin
            bad = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      poly_d  = poly_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SEND;
               cnt_d   = '0;
               poly_d  = poly_in;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               err_d   = bad;
            end
         end
         S_SEND: begin
            if (valid_q && out_ready) begin
               if (cnt_q == CNT_END) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
      data_d = valid_d ? packed_bits[cnt_d*DATA_OUT_BITS +: DATA_OUT_BITS] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         poly_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         poly_q  <= poly_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_eta_poly_pack.sv
// tb/tb_eta_poly_pack.sv - self-checking bench for eta_poly_pack with default parameters
// Expected words come from a bit-by-bit model of the packing rule over an integer coefficient array.
module tb_eta_poly_pack;

   localparam int N     = 256;
   localparam int ETA   = 2;
   localparam int CWID  = 4;
   localparam int DW    = 64;
   localparam int B     = 3;
   localparam int WORDS = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CWID*N-1:0] poly_in;
   logic [DW-1:0]     data_out;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic              err;

   int vectors = 0;
   int miscompares = 0;
   int coef [N];

   eta_poly_pack #(.N(N), .ETA(ETA), .COEFF_WIDTH(CWID), .DATA_OUT_BITS(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .poly_in   (poly_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_word(input int w);
      logic [63:0] r;
      int j, i, p;
      r = '0;
      for (int b = 0; b < DW; b++) begin
         j = w * DW + b;
         i = j / B;
         p = (((ETA - coef[i]) % 8) + 8) % 8;
         r[b] = ((p >> (j % B)) & 1) != 0;
      end
      return r;
   endfunction

   function automatic logic model_err();
      for (int i = 0; i < N; i++) begin
         if (coef[i] < -ETA || coef[i] > ETA) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic load_poly();
      int v;
      for (int i = 0; i < N; i++) begin
         v = coef[i];
         poly_in[i*CWID +: CWID] = v[CWID-1:0];
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // stall0: forced low-ready cycles on word 0; abort_after: reset once that many words accepted (-1 none)
   task automatic run_xfer(input int stall0, input bit rnd, input bit repulse, input int abort_after);
      int  w = 0;
      int  lows = 0;
      int  cyc = 0;
      bit  pulsed = 1'b0;
      bit  r;
      logic exp_err;
      exp_err = model_err();
      load_poly();
      start = 1'b1;
      out_ready = 1'b0;
      step();
      start = 1'b0;
      cyc = 1;
      chk("busy_after_start", busy, 1);
      chk("err_after_start", err, exp_err);
      while (w < WORDS) begin
         if (cyc > 400) begin
            chk("transfer_timeout", cyc, 0);
            return;
         end
         start = 1'b0;
         chk("valid_in_send", out_valid, 1);
         chk($sformatf("word%0d", w), data_out, model_word(w));
         if (abort_after >= 0 && w == abort_after) begin
            rst = 1'b1;
            out_ready = 1'b0;
            step();
            chk("abort_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_data", data_out, 0);
            chk("abort_err", err, 0);
            rst = 1'b0;
            step();
            chk("abort_no_done", done, 0);
            chk("abort_idle_valid", out_valid, 0);
            return;
         end
         if (repulse && w == 3 && !pulsed) begin
            poly_in = ~poly_in;
            start = 1'b1;
            pulsed = 1'b1;
         end
         if (w == 0 && lows < stall0) r = 1'b0;
         else if (rnd) r = ($urandom_range(0, 3) != 0);
         else r = 1'b1;
         if (!r) lows++;
         out_ready = r;
         step();
         cyc++;
         if (r) w++;
      end
      start = 1'b0;
      chk("done_pulse", done, 1);
      chk("valid_low_at_done", out_valid, 0);
      chk("data_zero_at_done", data_out, 0);
      chk("busy_at_done", busy, 1);
      chk("err_sticky", err, exp_err);
      chk("done_cycle", cyc, 13 + lows);
      step();
      chk("done_one_cycle", done, 0);
      chk("busy_idle", busy, 0);
      chk("data_zero_idle", data_out, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      poly_in = '0;
      repeat (3) step();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_data", data_out, 0);
      rst = 1'b0;
      step();

      for (int i = 0; i < N; i++) coef[i] = 0;
      run_xfer(0, 1'b0, 1'b0, -1);
      for (int i = 0; i < N; i++) coef[i] = 2;
      run_xfer(0, 1'b0, 1'b0, -1);
      for (int i = 0; i < N; i++) coef[i] = -2;
      run_xfer(0, 1'b0, 1'b0, -1);
      coef[0] = 3;
      for (int i = 1; i < N; i++) coef[i] = 2;
      run_xfer(0, 1'b0, 1'b0, -1);

      for (int i = 0; i < N; i++) coef[i] = $urandom_range(0, 4) - 2;
      run_xfer(5, 1'b0, 1'b0, -1);
      run_xfer(0, 1'b0, 1'b0, 4);
      run_xfer(0, 1'b0, 1'b0, -1);
      run_xfer(0, 1'b1, 1'b1, -1);

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) coef[i] = $urandom_range(0, 15) - 8;
         run_xfer(0, 1'b1, 1'b0, -1);
         for (int i = 0; i < N; i++) coef[i] = $urandom_range(0, 4) - 2;
         run_xfer(0, 1'b1, 1'b0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
